// File: rtl/chacha_key_loader.sv
// Byte-serial loader for the ChaCha block set-up (key, counter, nonce) with valid/ready hand-off to the core.
// Optional macro CHACHA_CTR_AUTOINC_EN: on block_done the counter increments and the set-up is reissued.
module chacha_key_loader #(
  parameter int KEY_BYTES   = 32,
  parameter int CTR_BYTES   = 4,
  parameter int NONCE_BYTES = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic         cfg_restart,
  output logic [255:0] key,
  output logic [31:0]  counter,
  output logic [95:0]  nonce,
  output logic         setup_valid,
  input  logic         core_ready,
  input  logic         block_done,
  output logic         ctr_wrap,
  output logic [1:0]   state_dbg,
  output logic [5:0]   byte_cnt_dbg
);

  // Handshakes: a byte moves when in_valid && in_ready at a rising edge; the
  // set-up moves to the core when setup_valid && core_ready at a rising edge.

  localparam logic [5:0] CTR_BASE   = 6'(KEY_BYTES);
  localparam logic [5:0] NONCE_BASE = 6'(KEY_BYTES + CTR_BYTES);
  localparam logic [5:0] LAST_BYTE  = 6'(KEY_BYTES + CTR_BYTES + NONCE_BYTES - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [5:0] byte_cnt;
  logic [5:0] next_cnt;
  logic [5:0] nonce_off;
  logic       load_fire;

  assign in_ready     = (state == LOAD);
  assign setup_valid  = (state == ISSUE);
  assign state_dbg    = state;
  assign byte_cnt_dbg = byte_cnt;
  assign load_fire    = (state == LOAD) && in_valid && !cfg_restart;
  assign nonce_off    = byte_cnt - NONCE_BASE;

  always_comb begin
    next_state = state;
    next_cnt   = byte_cnt;
    if (cfg_restart) begin
      next_state = LOAD;
      next_cnt   = 6'd0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (byte_cnt == LAST_BYTE) begin
              next_state = ISSUE;
              next_cnt   = 6'd0;
            end else begin
              next_cnt = byte_cnt + 6'd1;
            end
          end
        end
        ISSUE: begin
          if (core_ready) next_state = BUSY;
        end
        BUSY: begin
`ifdef CHACHA_CTR_AUTOINC_EN
          if (block_done) next_state = ISSUE;
`else
          if (block_done) next_state = LOAD;
`endif
        end
        default: begin
          next_state = LOAD;
          next_cnt   = 6'd0;
        end
      endcase
    end
  end

`ifdef CHACHA_CTR_AUTOINC_EN
  logic ctr_wrap_q;
  assign ctr_wrap = ctr_wrap_q;
`else
  assign ctr_wrap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      byte_cnt <= 6'd0;
      key      <= '0;
      counter  <= '0;
      nonce    <= '0;
`ifdef CHACHA_CTR_AUTOINC_EN
      ctr_wrap_q <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      byte_cnt <= next_cnt;
      // Bytes land straight in their little-endian word slot; no staging register.
      if (load_fire) begin
        if (byte_cnt < CTR_BASE)
          key[{byte_cnt[4:0], 3'b000} +: 8] <= in_data;
        else if (byte_cnt < NONCE_BASE)
          counter[{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
        else
          nonce[{nonce_off[3:0], 3'b000} +: 8] <= in_data;
      end
`ifdef CHACHA_CTR_AUTOINC_EN
      if (cfg_restart) begin
        ctr_wrap_q <= 1'b0;
      end else if (state == BUSY && block_done) begin
        counter <= counter + 32'd1;
        if (counter == 32'hFFFF_FFFF) ctr_wrap_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_chacha_key_loader.sv
// Directed bench for chacha_key_loader; expectations are hand-computed or packed from the byte vectors.
module tb_chacha_key_loader;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         cfg_restart;
  logic [255:0] key;
  logic [31:0]  counter;
  logic [95:0]  nonce;
  logic         setup_valid;
  logic         core_ready;
  logic         block_done;
  logic         ctr_wrap;
  logic [1:0]   state_dbg;
  logic [5:0]   byte_cnt_dbg;

  int n_cmp;
  int n_err;
  logic [7:0]   vec [48];
  logic [255:0] exp_q[$];
  logic [383:0] packed_exp;
  logic [255:0] key_snap;

  chacha_key_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cfg_restart  (cfg_restart),
    .key          (key),
    .counter      (counter),
    .nonce        (nonce),
    .setup_valid  (setup_valid),
    .core_ready   (core_ready),
    .block_done   (block_done),
    .ctr_wrap     (ctr_wrap),
    .state_dbg    (state_dbg),
    .byte_cnt_dbg (byte_cnt_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_vec();
    for (int i = 0; i < 48; i++) send_byte(vec[i]);
  endtask

  task automatic pulse_restart();
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
  endtask

  task automatic accept();
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
  endtask

  task automatic finish_block();
    block_done = 1'b1;
    tick();
    block_done = 1'b0;
  endtask

  function automatic logic [383:0] pack_vec();
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[8*i +: 8] = vec[i];
    return r;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    cfg_restart = 1'b0;
    core_ready = 1'b0;
    block_done = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_key", key, 256'h0);
    check("rst_counter", {224'h0, counter}, 256'h0);
    check("rst_nonce", {160'h0, nonce}, 256'h0);
    check("rst_setup_valid", {255'h0, setup_valid}, 256'h0);
    check("rst_in_ready", {255'h0, in_ready}, 256'h1);
    check("rst_ctr_wrap", {255'h0, ctr_wrap}, 256'h0);
    check("rst_state", {254'h0, state_dbg}, 256'h0);
    rst = 1'b0;
    tick();

    // 1: RFC 7539 2.3.2 set-up, in_valid held high
    for (int i = 0; i < 32; i++) vec[i] = 8'(i);
    vec[32] = 8'h01; vec[33] = 8'h00; vec[34] = 8'h00; vec[35] = 8'h00;
    for (int i = 36; i < 48; i++) vec[i] = 8'h00;
    vec[39] = 8'h09;
    vec[43] = 8'h4a;
    for (int i = 0; i < 47; i++) send_byte(vec[i]);
    check("t1_cnt_at_47", {250'h0, byte_cnt_dbg}, 256'd47);
    check("t1_sv_before_last", {255'h0, setup_valid}, 256'h0);
    send_byte(vec[47]);
    check("t1_key_w0", {224'h0, key[31:0]}, 256'h03020100);
    check("t1_key_w7", {224'h0, key[255:224]}, 256'h1f1e1d1c);
    check("t1_key", key, 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100);
    check("t1_counter", {224'h0, counter}, 256'h1);
    check("t1_nonce", {160'h0, nonce}, {160'h0, 96'h00000000_4a000000_09000000});
    check("t1_setup_valid", {255'h0, setup_valid}, 256'h1);
    check("t1_in_ready", {255'h0, in_ready}, 256'h0);
    check("t1_cnt_reset", {250'h0, byte_cnt_dbg}, 256'h0);

    // 2: gapped in_valid, core_ready low for 10 cycles; stray block_done ignored
    key_snap = key;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'($urandom_range(0, 255));
      block_done = (i == 4);
      tick();
      check("t2_setup_valid", {255'h0, setup_valid}, 256'h1);
      check("t2_key_hold", key, key_snap);
      check("t2_counter_hold", {224'h0, counter}, 256'h1);
    end
    in_valid = 1'b0;
    block_done = 1'b0;
    check("t2_in_ready", {255'h0, in_ready}, 256'h0);
    accept();
    check("t2_sv_dropped", {255'h0, setup_valid}, 256'h0);
    check("t2_state_busy", {254'h0, state_dbg}, 256'h2);

    // 3: block_done in BUSY
    finish_block();
`ifdef CHACHA_CTR_AUTOINC_EN
    check("t3_counter_inc", {224'h0, counter}, 256'h2);
    check("t3_setup_valid", {255'h0, setup_valid}, 256'h1);
    check("t3_key_kept", key, key_snap);
    pulse_restart();
`else
    check("t3_in_ready", {255'h0, in_ready}, 256'h1);
    check("t3_cnt_zero", {250'h0, byte_cnt_dbg}, 256'h0);
    check("t3_counter_kept", {224'h0, counter}, 256'h1);
`endif
    check("t3_state_load", {254'h0, state_dbg}, 256'h0);

    // 4: counter FF FF FF FF through one block
    for (int i = 32; i < 36; i++) vec[i] = 8'hFF;
    load_vec();
    check("t4_counter_loaded", {224'h0, counter}, 256'hFFFFFFFF);
    accept();
    finish_block();
`ifdef CHACHA_CTR_AUTOINC_EN
    check("t4_counter_wrapped", {224'h0, counter}, 256'h0);
    check("t4_ctr_wrap", {255'h0, ctr_wrap}, 256'h1);
    check("t4_reissue", {255'h0, setup_valid}, 256'h1);
`else
    check("t4_counter_untouched", {224'h0, counter}, 256'hFFFFFFFF);
    check("t4_ctr_wrap_tied", {255'h0, ctr_wrap}, 256'h0);
`endif
    pulse_restart();
    check("t4_wrap_cleared", {255'h0, ctr_wrap}, 256'h0);
    check("t4_state_load", {254'h0, state_dbg}, 256'h0);
`ifdef CHACHA_CTR_AUTOINC_EN
    check("t4_counter_kept", {224'h0, counter}, 256'h0);
`else
    check("t4_counter_kept", {224'h0, counter}, 256'hFFFFFFFF);
`endif

    // 5: 20 bytes, restart with a byte (dropped), then a full new set-up
    for (int i = 0; i < 20; i++) send_byte(8'hA0 + 8'(i));
    check("t5_cnt_20", {250'h0, byte_cnt_dbg}, 256'd20);
    in_valid = 1'b1;
    in_data  = 8'h55;
    pulse_restart();
    in_valid = 1'b0;
    check("t5_cnt_restart", {250'h0, byte_cnt_dbg}, 256'h0);
    check("t5_sv_restart", {255'h0, setup_valid}, 256'h0);
    send_byte(8'h80);
    check("t5_drop", {240'h0, key[15:0]}, {240'h0, 16'hA180});
    for (int i = 0; i < 48; i++) vec[i] = 8'h80 + 8'(3 * i);
    for (int i = 1; i < 48; i++) send_byte(vec[i]);
    packed_exp = pack_vec();
    exp_q.push_back(packed_exp[255:0]);
    exp_q.push_back({224'h0, packed_exp[287:256]});
    exp_q.push_back({160'h0, packed_exp[383:288]});
    check("t5_key", key, exp_q.pop_front());
    check("t5_counter", {224'h0, counter}, exp_q.pop_front());
    check("t5_nonce", {160'h0, nonce}, exp_q.pop_front());
    check("t5_setup_valid", {255'h0, setup_valid}, 256'h1);

    // 6: asynchronous reset between edges while BUSY
    accept();
    check("t6_busy", {254'h0, state_dbg}, 256'h2);
    #3;
    rst = 1'b1;
    #1;
    check("t6_key", key, 256'h0);
    check("t6_counter", {224'h0, counter}, 256'h0);
    check("t6_nonce", {160'h0, nonce}, 256'h0);
    check("t6_setup_valid", {255'h0, setup_valid}, 256'h0);
    check("t6_in_ready", {255'h0, in_ready}, 256'h1);
    check("t6_state", {254'h0, state_dbg}, 256'h0);
    tick();
    rst = 1'b0;
    tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
